// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the store buffer: widths, instruction fields,
// buffer entry layout and the effective-address helper.
package cpu_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int OFF_LSB = 0;
  localparam int OFF_MSB = 15;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  // Word address wraps modulo the data memory size.
  function automatic logic [ADDR_W-1:0] calc_ea(input logic [ADDR_W-1:0] base_lo,
                                                input logic [ADDR_W-1:0] off_lo);
    return base_lo + off_lo;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Execute-stage request, data-memory port and load-response signals of the store buffer.
interface store_buffer_if;
  import cpu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [DATA_W-1:0] req_base;
  logic [31:0]       req_instr;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_busy;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              empty;

  modport slave (
    input  req_valid, req_is_store, req_base, req_instr, req_wdata, mem_busy, mem_rdata,
    output req_ready, mem_we, mem_re, mem_addr, mem_wdata, ld_valid, ld_data, empty
  );

  modport master (
    output req_valid, req_is_store, req_base, req_instr, req_wdata, mem_busy, mem_rdata,
    input  req_ready, mem_we, mem_re, mem_addr, mem_wdata, ld_valid, ld_data, empty
  );

endinterface

// File: rtl/sb_match.sv
// Associative lookup over the buffered stores: reports whether the load address
// is present and returns the data of the youngest matching entry.
module sb_match
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t         entries_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [PTR_W-1:0]  head_i,
  input  logic [ADDR_W-1:0] ea_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] fwd_o
);

  // NOTE: outputs get defaults before the loop so no path leaves them unassigned
  // (no latch); walking oldest to youngest lets the last match win.
  always_comb begin
    hit_o = 1'b0;
    fwd_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_i[head_i + PTR_W'(k)] && entries_i[head_i + PTR_W'(k)].addr == ea_i) begin
        hit_o = 1'b1;
        fwd_o = entries_i[head_i + PTR_W'(k)].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between execute and data memory: in-order store drain, one memory
// access per cycle, store-to-load forwarding and a registered load response.
module store_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  store_buffer_if.slave sb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t         entries_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ld_valid_q, ld_valid_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;

  logic [ADDR_W-1:0] ea;
  logic [DEPTH-1:0]  valid_mask;
  logic              hit;
  logic [DATA_W-1:0] fwd;
  logic              not_full, ready, accept, push, load_acc, load_miss, drain;
  sb_entry_t         head_ent;
  logic              unused_bits;

  assign ea          = calc_ea(sb.req_base[ADDR_W-1:0], sb.req_instr[OFF_LSB +: ADDR_W]);
  assign unused_bits = ^{sb.req_base[DATA_W-1:ADDR_W], sb.req_instr[31:OFF_LSB+ADDR_W]};

  // A slot is live when its distance from head is below the occupancy count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PTR_W-1:0] age;
    assign age           = PTR_W'(i) - head_q;
    assign valid_mask[i] = {1'b0, age} < count_q;
  end

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries_i (entries_q),
    .valid_i   (valid_mask),
    .head_i    (head_q),
    .ea_i      (ea),
    .hit_o     (hit),
    .fwd_o     (fwd)
  );

  assign not_full = count_q < CNT_W'(DEPTH);

  always_comb begin
    ready = 1'b0;
    if (!reset) begin
      if (sb.req_is_store) ready = not_full;
      else                 ready = hit | (~sb.mem_busy & not_full);
    end
  end

  assign accept    = sb.req_valid & ready;
  assign push      = accept & sb.req_is_store;
  assign load_acc  = accept & ~sb.req_is_store;
  assign load_miss = load_acc & ~hit;
  // A load miss owns the memory port; a hit leaves it free for a drain.
  assign drain     = ~reset & ~load_miss & (count_q != '0) & ~sb.mem_busy;

  always_comb begin
    head_ent = '0;
    if (!reset && count_q != '0) head_ent = entries_q[head_q];
  end

  assign sb.req_ready = ready;
  assign sb.mem_we    = drain;
  assign sb.mem_re    = load_miss;
  assign sb.mem_addr  = load_miss ? ea : head_ent.addr;
  assign sb.mem_wdata = head_ent.data;
  assign sb.empty     = reset | (count_q == '0);
  assign sb.ld_valid  = ld_valid_q & ~reset;
  assign sb.ld_data   = reset ? '0 : ld_data_q;

  always_comb begin
    head_d     = drain ? head_q + PTR_W'(1) : head_q;
    tail_d     = push  ? tail_q + PTR_W'(1) : tail_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(drain);
    ld_valid_d = load_acc;
    ld_data_d  = ld_data_q;
    if (load_acc) ld_data_d = hit ? fwd : sb.mem_rdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; liveness comes from count_q,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= '{addr: ea, data: sb.req_wdata};
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_store_buffer;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if sb ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ment_t;

  typedef struct {
    logic              ready, we, re, empty, ldv, push, load_acc, load_miss, drain, hit, chk_wdata;
    logic [ADDR_W-1:0] ea, addr;
    logic [DATA_W-1:0] wdata, ldd, fwd;
  } pred_t;

  ment_t             mq[$];
  logic              mdl_ldv = 1'b0;
  logic [DATA_W-1:0] mdl_ldd = '0;
  pred_t             cmp_p, upd_p;

  function automatic pred_t predict();
    pred_t       p;
    int unsigned e;
    p = '{default: '0};
    if (reset) begin
      p.empty     = 1'b1;
      p.chk_wdata = 1'b1;
      return p;
    end
    e    = (sb.req_base % (2 ** ADDR_W) + 32'(sb.req_instr[15:0])) % (2 ** ADDR_W);
    p.ea = ADDR_W'(e);
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == p.ea) begin
        p.hit = 1'b1;
        p.fwd = mq[i].data;
        break;
      end
    end
    if (sb.req_is_store) p.ready = mq.size() < DEPTH;
    else                 p.ready = p.hit || (!sb.mem_busy && mq.size() < DEPTH);
    p.push      = sb.req_valid && p.ready && sb.req_is_store;
    p.load_acc  = sb.req_valid && p.ready && !sb.req_is_store;
    p.load_miss = p.load_acc && !p.hit;
    p.drain     = !p.load_miss && mq.size() > 0 && !sb.mem_busy;
    p.chk_wdata = !p.load_miss;
    if (p.load_miss) begin
      p.re   = 1'b1;
      p.addr = p.ea;
    end else if (mq.size() > 0) begin
      p.we    = p.drain;
      p.addr  = mq[0].addr;
      p.wdata = mq[0].data;
    end
    p.ldv   = mdl_ldv;
    p.ldd   = mdl_ldd;
    p.empty = mq.size() == 0;
    return p;
  endfunction

  always @(posedge clk) begin
    upd_p = predict();
    if (reset) begin
      mq.delete();
      mdl_ldv = 1'b0;
      mdl_ldd = '0;
    end else begin
      if (upd_p.drain) void'(mq.pop_front());
      if (upd_p.push)  mq.push_back('{addr: upd_p.ea, data: sb.req_wdata});
      mdl_ldv = upd_p.load_acc;
      if (upd_p.load_acc) mdl_ldd = upd_p.hit ? upd_p.fwd : sb.mem_rdata;
    end
  end

  always @(negedge clk) begin
    cmp_p = predict();
    check("req_ready", 64'(sb.req_ready), 64'(cmp_p.ready));
    check("mem_we",    64'(sb.mem_we),    64'(cmp_p.we));
    check("mem_re",    64'(sb.mem_re),    64'(cmp_p.re));
    check("mem_addr",  64'(sb.mem_addr),  64'(cmp_p.addr));
    if (cmp_p.chk_wdata) check("mem_wdata", 64'(sb.mem_wdata), 64'(cmp_p.wdata));
    check("ld_valid",  64'(sb.ld_valid),  64'(cmp_p.ldv));
    check("ld_data",   64'(sb.ld_data),   64'(cmp_p.ldd));
    check("empty",     64'(sb.empty),     64'(cmp_p.empty));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic [31:0] base, input logic [15:0] off,
                           input logic [31:0] wdata, input logic busy, input logic [31:0] rdata);
    sb.req_valid    = 1'b1;
    sb.req_is_store = st;
    sb.req_base     = base;
    sb.req_instr    = {st ? OP_SW : OP_LW, 10'($urandom), off};
    sb.req_wdata    = wdata;
    sb.mem_busy     = busy;
    sb.mem_rdata    = rdata;
  endtask

  task automatic idle(input logic busy);
    sb.req_valid    = 1'b0;
    sb.req_is_store = 1'b0;
    sb.mem_busy     = busy;
    sb.mem_rdata    = $urandom;
  endtask

  initial begin
    reset           = 1'b1;
    sb.req_valid    = 1'b0;
    sb.req_is_store = 1'b0;
    sb.req_base     = '0;
    sb.req_instr    = '0;
    sb.req_wdata    = '0;
    sb.mem_busy     = 1'b0;
    sb.mem_rdata    = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: plain store drains the cycle after acceptance
    tick(); drive_req(1, 16, 5, 77, 0, 0); #6 check("t1_ready", 64'(sb.req_ready), 1);
    tick(); idle(0); #6
    check("t1_we", 64'(sb.mem_we), 1);
    check("t1_addr", 64'(sb.mem_addr), 21);
    check("t1_wdata", 64'(sb.mem_wdata), 77);
    tick(); idle(0); #6 check("t1_empty", 64'(sb.empty), 1);

    // 2: load right behind a store is forwarded, no memory read
    tick(); drive_req(1, 30, 0, 9, 0, 0);
    tick(); drive_req(0, 30, 0, 0, 0, 0); #6 check("t2_re", 64'(sb.mem_re), 0);
    tick(); idle(0); #6
    check("t2_ldv", 64'(sb.ld_valid), 1);
    check("t2_ldd", 64'(sb.ld_data), 9);

    // 3: youngest of two same-address stores wins
    tick(); drive_req(1, 40, 0, 1, 1, 0);
    tick(); drive_req(1, 40, 0, 2, 1, 0);
    tick(); drive_req(0, 40, 0, 0, 1, 0); #6 check("t3_we_busy", 64'(sb.mem_we), 0);
    tick(); idle(1); #6
    check("t3_ldd", 64'(sb.ld_data), 2);
    check("t3_we_busy2", 64'(sb.mem_we), 0);
    for (int i = 0; i < 3; i++) begin tick(); idle(0); end

    // 4: full buffer stalls stores, still accepts hits, then drains in order
    for (int i = 1; i <= 4; i++) begin
      tick(); drive_req(1, 32'(i), 0, 32'(i), 1, 0); #6 check("t4_fill_ready", 64'(sb.req_ready), 1);
    end
    tick(); drive_req(1, 5, 0, 5, 1, 0); #6 check("t4_full_ready", 64'(sb.req_ready), 0);
    tick(); drive_req(0, 3, 0, 0, 1, 0); #6 check("t4_hit_ready", 64'(sb.req_ready), 1);
    tick(); idle(0); #6
    check("t4_ldv", 64'(sb.ld_valid), 1);
    check("t4_ldd", 64'(sb.ld_data), 3);
    check("t4_we1", 64'(sb.mem_we), 1);
    check("t4_addr1", 64'(sb.mem_addr), 1);
    for (int j = 2; j <= 4; j++) begin
      tick(); idle(0); #6
      check("t4_we", 64'(sb.mem_we), 1);
      check("t4_addr", 64'(sb.mem_addr), 64'(j));
    end
    tick(); idle(0); #6 check("t4_empty", 64'(sb.empty), 1);

    // 5: address wrap and load miss via memory read
    tick(); drive_req(1, 1020, 10, 5, 0, 0);
    tick(); idle(0); #6
    check("t5_we", 64'(sb.mem_we), 1);
    check("t5_addr_wrap", 64'(sb.mem_addr), 6);
    tick(); drive_req(0, 100, 0, 0, 0, 42); #6
    check("t5_re", 64'(sb.mem_re), 1);
    check("t5_re_addr", 64'(sb.mem_addr), 100);
    tick(); idle(0); #6
    check("t5_ldv", 64'(sb.ld_valid), 1);
    check("t5_ldd", 64'(sb.ld_data), 42);

    // 6: reset discards buffered stores and a pending load response
    for (int i = 0; i < 3; i++) begin tick(); drive_req(1, 32'(50 + i), 0, 32'(i + 7), 1, 0); end
    tick(); drive_req(0, 51, 0, 0, 1, 0);
    tick(); idle(1); reset = 1'b1; #6
    check("t6_rst_ready", 64'(sb.req_ready), 0);
    check("t6_rst_ldv", 64'(sb.ld_valid), 0);
    check("t6_rst_empty", 64'(sb.empty), 1);
    for (int i = 0; i < 4; i++) begin
      tick(); reset = 1'b0; idle(0); #6
      check("t6_empty", 64'(sb.empty), 1);
      check("t6_we", 64'(sb.mem_we), 0);
      check("t6_ldv", 64'(sb.ld_valid), 0);
    end

    // randomized traffic over a small, partly wrapping address window
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] base;
      tick();
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0)
        base = ($urandom & ~32'h3FF) | 32'(1020 + $urandom_range(0, 3));
      else
        base = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7)
        drive_req(1'($urandom_range(0, 1)), base, 16'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 3), $urandom);
      else
        idle($urandom_range(0, 9) < 3);
    end

    tick(); reset = 1'b0; idle(0);
    for (int i = 0; i < 6; i++) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
